// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared definitions for the fifo36 sequence checker.
// State encoding, fifo36 flag positions, control register offset and
// sequence arithmetic helpers. S_DROP exists only when SEQ_STALE_DROP_EN
// is defined.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    S_SEQ   = 2'd0,
    S_FIRST = 2'd1,
`ifdef SEQ_STALE_DROP_EN
    S_BODY  = 2'd2,
    S_DROP  = 2'd3
`else
    S_BODY  = 2'd2
`endif
  } state_t;

  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;

  localparam logic [7:0] CTRL_OFFSET = 8'd0;

  // Next in-order sequence number; 0xFFFFFFFF wraps to 0.
  function automatic logic [31:0] seq_next(input logic [31:0] seq);
    return seq + 32'd1;
  endfunction

  // A word is stale (old or duplicate) when (data - expected) is negative
  // as a signed 32-bit value.
  function automatic logic seq_is_stale(input logic [31:0] data,
                                        input logic [31:0] expected);
    logic [31:0] diff;
    diff = data - expected;
    return diff[31];
  endfunction

endpackage

// File: rtl/setting_reg.sv
// setting_reg: one register on the setting bus.
// Loads din when strobe is high and addr matches MY_ADDR. Cleared by the
// asynchronous reset and by the synchronous clear.
module setting_reg #(
  parameter logic [7:0] MY_ADDR  = 8'd0,
  parameter int         WIDTH    = 1,
  parameter logic [WIDTH-1:0] AT_RESET = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] value_r;

  // Hold the register value; write on an address match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= AT_RESET;
    end else if (clr) begin
      value_r <= AT_RESET;
    end else if (strobe && (addr == MY_ADDR)) begin
      value_r <= din;
    end else begin
      value_r <= value_r;
    end
  end

  assign dout = value_r;

endmodule

// File: rtl/dsp_seq_checker36.sv
// dsp_seq_checker36: strips the leading UDP sequence word of each fifo36
// frame, checks it against last_seq + 1 and forwards the rest of the frame
// with SOF moved onto the VRT header line, through a registered output stage.
// Optional feature: SEQ_STALE_DROP_EN drops frames whose sequence word is
// stale or duplicated.
module dsp_seq_checker36
  import dsp_seq_pkg::*;
#(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] inp_data,
  input  logic        inp_valid,
  output logic        inp_ready,
  output logic [35:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        seq_err,
  output logic [31:0] seq_err_count,
  output logic [15:0] runt_count,
  output logic [31:0] last_seq
);

  state_t      state_r;
  state_t      state_s;

  logic        check_en_s;
  logic        ctrl_wr_s;
  logic        synced_r;
  logic [31:0] last_seq_r;
  logic [31:0] expected_s;
  logic [31:0] seq_err_count_r;
  logic [15:0] runt_count_r;
  logic        seq_err_r;
  logic [35:0] out_data_r;
  logic        out_valid_r;

  logic        sof_s;
  logic        eof_s;
  logic        fwd_ready_s;
  logic        check_active_s;
  logic        inp_ready_s;
  logic        load_s;
  logic        force_sof_s;
  logic        capture_s;
  logic        update_seq_s;
  logic        runt_s;
  logic        mismatch_s;
  logic [35:0] load_data_s;
  logic        unused_set_data_s;

  setting_reg #(
    .MY_ADDR  (BASE + CTRL_OFFSET),
    .WIDTH    (1),
    .AT_RESET (1'b0)
  ) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .strobe (set_stb),
    .addr   (set_addr),
    .din    (set_data[0:0]),
    .dout   (check_en_s)
  );

  assign unused_set_data_s = ^set_data[31:1];

  assign ctrl_wr_s      = set_stb && (set_addr == (BASE + CTRL_OFFSET));
  assign sof_s          = inp_data[SOF_BIT];
  assign eof_s          = inp_data[EOF_BIT];
  assign expected_s     = seq_next(last_seq_r);
  assign fwd_ready_s    = !out_valid_r || out_ready;
  assign check_active_s = check_en_s && synced_r;

  // Next state, input handshake and per-line actions.
  always_comb begin
    state_s      = state_r;
    inp_ready_s  = 1'b1;
    load_s       = 1'b0;
    force_sof_s  = 1'b0;
    capture_s    = 1'b0;
    update_seq_s = 1'b0;
    runt_s       = 1'b0;
    mismatch_s   = 1'b0;
    case (state_r)
      S_SEQ: begin
        inp_ready_s = 1'b1;
        if (inp_valid && sof_s) begin
          capture_s  = 1'b1;
          runt_s     = eof_s;
          mismatch_s = check_active_s && (inp_data[31:0] != expected_s);
`ifdef SEQ_STALE_DROP_EN
          if (check_active_s && seq_is_stale(inp_data[31:0], expected_s)) begin
            update_seq_s = 1'b0;
            state_s      = eof_s ? S_SEQ : S_DROP;
          end else begin
            update_seq_s = 1'b1;
            state_s      = eof_s ? S_SEQ : S_FIRST;
          end
`else
          update_seq_s = 1'b1;
          state_s      = eof_s ? S_SEQ : S_FIRST;
`endif
        end else begin
          state_s = S_SEQ;
        end
      end
      S_FIRST: begin
        inp_ready_s = fwd_ready_s;
        if (inp_valid && fwd_ready_s) begin
          load_s      = 1'b1;
          force_sof_s = 1'b1;
          state_s     = eof_s ? S_SEQ : S_BODY;
        end else begin
          state_s = S_FIRST;
        end
      end
      S_BODY: begin
        inp_ready_s = fwd_ready_s;
        if (inp_valid && fwd_ready_s) begin
          load_s  = 1'b1;
          state_s = eof_s ? S_SEQ : S_BODY;
        end else begin
          state_s = S_BODY;
        end
      end
`ifdef SEQ_STALE_DROP_EN
      S_DROP: begin
        inp_ready_s = 1'b1;
        if (inp_valid && eof_s) begin
          state_s = S_SEQ;
        end else begin
          state_s = S_DROP;
        end
      end
`endif
      default: begin
        inp_ready_s = 1'b1;
        state_s     = S_SEQ;
      end
    endcase
  end

  // VRT header line gets SOF re-asserted; other lines pass unchanged.
  always_comb begin
    load_data_s = inp_data;
    if (force_sof_s) begin
      load_data_s[SOF_BIT] = 1'b1;
    end else begin
      load_data_s[SOF_BIT] = inp_data[SOF_BIT];
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_SEQ;
    end else if (clr) begin
      state_r <= S_SEQ;
    end else begin
      state_r <= state_s;
    end
  end

  // Output register: load on input transfer, empty on drain without reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 36'd0;
    end else if (clr) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 36'd0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= load_data_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

  // Captured sequence word and sync flag; a control write forgets sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_seq_r <= 32'd0;
      synced_r   <= 1'b0;
    end else if (clr) begin
      last_seq_r <= 32'd0;
      synced_r   <= 1'b0;
    end else begin
      if (update_seq_s) begin
        last_seq_r <= inp_data[31:0];
      end else begin
        last_seq_r <= last_seq_r;
      end
      if (ctrl_wr_s) begin
        synced_r <= 1'b0;
      end else if (capture_s) begin
        synced_r <= 1'b1;
      end else begin
        synced_r <= synced_r;
      end
    end
  end

  // Mismatch pulse and saturating counters; a control write clears the counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err_r       <= 1'b0;
      seq_err_count_r <= 32'd0;
      runt_count_r    <= 16'd0;
    end else if (clr) begin
      seq_err_r       <= 1'b0;
      seq_err_count_r <= 32'd0;
      runt_count_r    <= 16'd0;
    end else begin
      seq_err_r <= mismatch_s;
      if (ctrl_wr_s) begin
        seq_err_count_r <= 32'd0;
      end else if (mismatch_s && (seq_err_count_r != 32'hFFFF_FFFF)) begin
        seq_err_count_r <= seq_err_count_r + 32'd1;
      end else begin
        seq_err_count_r <= seq_err_count_r;
      end
      if (ctrl_wr_s) begin
        runt_count_r <= 16'd0;
      end else if (runt_s && (runt_count_r != 16'hFFFF)) begin
        runt_count_r <= runt_count_r + 16'd1;
      end else begin
        runt_count_r <= runt_count_r;
      end
    end
  end

  assign inp_ready     = inp_ready_s;
  assign out_data      = out_data_r;
  assign out_valid     = out_valid_r;
  assign seq_err       = seq_err_r;
  assign seq_err_count = seq_err_count_r;
  assign runt_count    = runt_count_r;
  assign last_seq      = last_seq_r;

endmodule

// File: tb/tb_dsp_seq_checker36.sv
// tb_dsp_seq_checker36: directed frames with a scoreboard queue of expected
// output lines, popped by a monitor on every output transfer.
module tb_dsp_seq_checker36;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [35:0] inp_data = 36'd0;
  logic        inp_valid = 1'b0;
  logic        inp_ready;
  logic [35:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        seq_err;
  logic [31:0] seq_err_count;
  logic [15:0] runt_count;
  logic [31:0] last_seq;

  int          total = 0;
  int          bad = 0;
  int          err_pulses = 0;
  int          pulses_before;
  bit          bp_mode = 1'b0;
  logic [35:0] exp_q[$];
  logic [35:0] mon_exp;

  dsp_seq_checker36 #(.BASE(8'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .set_stb       (set_stb),
    .set_addr      (set_addr),
    .set_data      (set_data),
    .inp_data      (inp_data),
    .inp_valid     (inp_valid),
    .inp_ready     (inp_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .seq_err       (seq_err),
    .seq_err_count (seq_err_count),
    .runt_count    (runt_count),
    .last_seq      (last_seq)
  );

  always #5 clk = ~clk;

  // Monitor: pop and compare on each output transfer, count seq_err pulses.
  always @(negedge clk) begin
    if (rst_n && seq_err) err_pulses++;
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected actual=%h required=none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          bad++;
          $display("FAIL out_data actual=%h required=%h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_mode) out_ready = ~out_ready;
  endtask

  task automatic ctrl_write(input logic [7:0] addr, input logic [31:0] d);
    set_stb = 1'b1; set_addr = addr; set_data = d;
    step();
    set_stb = 1'b0;
  endtask

  // Present one line until accepted; optionally a control write in the first cycle.
  task automatic send_line(input logic [35:0] d, input bit wr);
    int  n;
    bit  done;
    n = 0; done = 1'b0;
    inp_data = d; inp_valid = 1'b1;
    if (wr) begin
      set_stb = 1'b1; set_addr = 8'd0; set_data = 32'd1;
    end
    while (!done && n < 200) begin
      @(negedge clk);
      done = inp_ready;
      step();
      set_stb = 1'b0;
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout actual=stalled required=accepted");
    end
  endtask

  // Sequence line then nlines payload lines; exp_err>=0 checks seq_err right after capture.
  task automatic send_frame(input logic [31:0] seq, input int nlines, input logic [31:0] base,
                            input bit fwd, input bit wr, input int exp_err);
    logic [35:0] d;
    d = {2'b00, (nlines == 0), 1'b1, seq};
    send_line(d, wr);
    if (exp_err >= 0) chk("seq_err_pulse", {35'd0, seq_err}, exp_err[35:0]);
    for (int i = 0; i < nlines; i++) begin
      d = {((i == nlines - 1) ? 2'b10 : 2'b00), (i == nlines - 1), 1'b0, base + i};
      if (fwd) begin
        if (i == 0) exp_q.push_back({d[35:33], 1'b1, d[31:0]});
        else        exp_q.push_back(d);
      end
      send_line(d, 1'b0);
    end
    inp_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) step();
    chk("queue_empty", exp_q.size(), 36'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_out_valid", out_valid, 36'd0);
    chk("rst_out_data", out_data, 36'd0);
    chk("rst_seq_err", seq_err, 36'd0);
    chk("rst_err_count", seq_err_count, 36'd0);
    chk("rst_runt_count", runt_count, 36'd0);
    chk("rst_last_seq", last_seq, 36'd0);
    chk("rst_inp_ready", inp_ready, 36'd1);
    rst_n = 1'b1;
    step();
    ctrl_write(8'd0, 32'd1);

    // In-order 5,6,7
    pulses_before = err_pulses;
    send_frame(32'd5, 3, 32'h100, 1'b1, 1'b0, 0);
    send_frame(32'd6, 3, 32'h200, 1'b1, 1'b0, 0);
    send_frame(32'd7, 3, 32'h300, 1'b1, 1'b0, 0);
    drain();
    chk("inorder_count", seq_err_count, 36'd0);
    chk("inorder_last_seq", last_seq, 36'd7);
    chk("inorder_pulses", err_pulses - pulses_before, 36'd0);

    // Gap 10 -> 12
    ctrl_write(8'd0, 32'd1);
    pulses_before = err_pulses;
    send_frame(32'd10, 2, 32'h400, 1'b1, 1'b0, 0);
    send_frame(32'd12, 2, 32'h500, 1'b1, 1'b0, 1);
    drain();
    chk("gap_count", seq_err_count, 36'd1);
    chk("gap_pulses", err_pulses - pulses_before, 36'd1);
    chk("gap_last_seq", last_seq, 36'd12);

    // Wrap
    ctrl_write(8'd0, 32'd1);
    chk("ctrl_clears_count", seq_err_count, 36'd0);
    pulses_before = err_pulses;
    send_frame(32'hFFFF_FFFF, 2, 32'h600, 1'b1, 1'b0, 0);
    send_frame(32'h0000_0000, 2, 32'h700, 1'b1, 1'b0, 0);
    drain();
    chk("wrap_count", seq_err_count, 36'd0);
    chk("wrap_pulses", err_pulses - pulses_before, 36'd0);
    chk("wrap_last_seq", last_seq, 36'd0);

    // Runt
    send_frame(32'd1, 0, 32'd0, 1'b1, 1'b0, 0);
    drain();
    chk("runt_count", runt_count, 36'd1);
    chk("runt_last_seq", last_seq, 36'd1);

    // Backpressure over a 6-line frame
    bp_mode = 1'b1;
    send_frame(32'd2, 5, 32'h800, 1'b1, 1'b0, 0);
    repeat (12) step();
    bp_mode = 1'b0; out_ready = 1'b1;
    drain();
    chk("bp_count", seq_err_count, 36'd0);

    // Checking disabled: stale word is not flagged and is captured
    ctrl_write(8'd0, 32'd0);
    pulses_before = err_pulses;
    send_frame(32'd100, 2, 32'h900, 1'b1, 1'b0, 0);
    send_frame(32'd50, 2, 32'hA00, 1'b1, 1'b0, 0);
    drain();
    chk("nochk_count", seq_err_count, 36'd0);
    chk("nochk_pulses", err_pulses - pulses_before, 36'd0);
    chk("nochk_last_seq", last_seq, 36'd50);

    // Control write in the mismatch cycle: clear wins
    ctrl_write(8'd0, 32'd1);
    send_frame(32'd60, 1, 32'hB00, 1'b1, 1'b0, -1);
    send_frame(32'd70, 1, 32'hC00, 1'b1, 1'b1, -1);
    drain();
    chk("wr_vs_err_count", seq_err_count, 36'd0);

    // clr mid-frame with a stalled output register
    out_ready = 1'b0;
    send_line({2'b00, 1'b0, 1'b1, 32'd80}, 1'b0);
    send_line({2'b00, 1'b0, 1'b0, 32'hD00}, 1'b0);
    inp_valid = 1'b0;
    step();
    chk("stall_out_valid", out_valid, 36'd1);
    chk("stall_out_data", out_data, {2'b00, 1'b0, 1'b1, 32'hD00});
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_out_valid", out_valid, 36'd0);
    chk("clr_last_seq", last_seq, 36'd0);
    chk("clr_runt_count", runt_count, 36'd0);
    out_ready = 1'b1;
    send_line({2'b00, 1'b0, 1'b0, 32'hD01}, 1'b0);
    send_line({2'b00, 1'b1, 1'b0, 32'hD02}, 1'b0);
    inp_valid = 1'b0;
    send_frame(32'd3, 2, 32'hE00, 1'b1, 1'b0, 0);
    drain();
    chk("clr_after_last_seq", last_seq, 36'd3);

`ifdef SEQ_STALE_DROP_EN
    // Stale drop 20 -> 19
    ctrl_write(8'd0, 32'd1);
    send_frame(32'd20, 2, 32'hF00, 1'b1, 1'b0, 0);
    send_frame(32'd19, 2, 32'hF10, 1'b0, 1'b0, 1);
    drain();
    chk("stale_count", seq_err_count, 36'd1);
    chk("stale_last_seq", last_seq, 36'd20);
    ctrl_write(8'd0, 32'd1);
    chk("stale_clear", seq_err_count, 36'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
